// File: rtl/circuito_exp4_desafio_pkg.sv
// Shared definitions for the memory game: FSM state codes, sequence ROM and
// default inactivity timeout.
package circuito_exp4_desafio_pkg;

   localparam int TIMEOUT_CYCLES_DEF = 5000;

   // State encodings double as the hex digit shown on the state display.
   typedef enum logic [3:0] {
      ST_INICIAL     = 4'h0,
      ST_PREPARACAO  = 4'h1,
      ST_ESPERA      = 4'h2,
      ST_REGISTRA    = 4'h4,
      ST_COMPARACAO  = 4'h5,
      ST_PROXIMO     = 4'h6,
      ST_FIM_ACERTOU = 4'hA,
      ST_FIM_TIMEOUT = 4'hD,
      ST_FIM_ERROU   = 4'hE
   } state_t;

   typedef struct packed {
      logic acertou;
      logic errou;
      logic pronto;
      logic timeout;
   } status_t;

   function automatic logic [3:0] rom_read(input logic [3:0] addr);
      logic [3:0] dado;
      case (addr)
         4'd0:  dado = 4'b0001;
         4'd1:  dado = 4'b0010;
         4'd2:  dado = 4'b0100;
         4'd3:  dado = 4'b1000;
         4'd4:  dado = 4'b0100;
         4'd5:  dado = 4'b0010;
         4'd6:  dado = 4'b0001;
         4'd7:  dado = 4'b0001;
         4'd8:  dado = 4'b0010;
         4'd9:  dado = 4'b0010;
         4'd10: dado = 4'b0100;
         4'd11: dado = 4'b0100;
         4'd12: dado = 4'b1000;
         4'd13: dado = 4'b1000;
         4'd14: dado = 4'b0001;
         default: dado = 4'b0100;
      endcase
      return dado;
   endfunction

   function automatic status_t status_of(input state_t s);
      status_t st;
      st = '0;
      case (s)
         ST_FIM_ACERTOU: begin st.acertou = 1'b1; st.pronto = 1'b1; end
         ST_FIM_ERROU:   begin st.errou = 1'b1; st.pronto = 1'b1; end
         ST_FIM_TIMEOUT: begin st.errou = 1'b1; st.pronto = 1'b1; st.timeout = 1'b1; end
         default: st = '0;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/circuito_exp4_desafio_hexa7seg.sv
// Hex digit to active-low 7-segment decoder, segment order {g,f,e,d,c,b,a}.
module hexa7seg (
   input  logic [3:0] i_hexa,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = 7'b1111111;
      case (i_hexa)
         4'h0: o_seg = 7'b1000000;
         4'h1: o_seg = 7'b1111001;
         4'h2: o_seg = 7'b0100100;
         4'h3: o_seg = 7'b0110000;
         4'h4: o_seg = 7'b0011001;
         4'h5: o_seg = 7'b0010010;
         4'h6: o_seg = 7'b0000010;
         4'h7: o_seg = 7'b1111000;
         4'h8: o_seg = 7'b0000000;
         4'h9: o_seg = 7'b0010000;
         4'hA: o_seg = 7'b0001000;
         4'hB: o_seg = 7'b0000011;
         4'hC: o_seg = 7'b1000110;
         4'hD: o_seg = 7'b0100001;
         4'hE: o_seg = 7'b0000110;
         default: o_seg = 7'b0001110;
      endcase
   end

endmodule

// File: rtl/circuito_exp4_desafio.sv
// Memory game top: Moore FSM plus address counter, play register, edge
// detector and inactivity timer; status flags are registered from next state.
module circuito_exp4_desafio
   import circuito_exp4_desafio_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic [3:0] chaves,
   output logic       acertou,
   output logic       errou,
   output logic       pronto,
   output logic [3:0] leds,
   output logic       db_igual,
   output logic       db_timeout,
   output logic [6:0] db_contagem,
   output logic [6:0] db_memoria,
   output logic [6:0] db_estado,
   output logic [6:0] db_jogadafeita,
   output logic       db_clock,
   output logic       db_iniciar,
   output logic       db_tem_jogada
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TC_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_t        r_state;
   state_t        w_next;
   status_t       r_status;
   logic [3:0]    r_contagem;
   logic [3:0]    r_jogada;
   logic [TW-1:0] r_timer;
   logic          r_prev;
   logic          w_tem_jogada;
   logic          w_jogada;
   logic          w_igual;
   logic [3:0]    w_dado;
   logic [3:0]    w_estado_code;

   assign w_tem_jogada  = |chaves;
   assign w_jogada      = w_tem_jogada & ~r_prev;
   assign w_dado        = rom_read(r_contagem);
   assign w_igual       = (r_jogada == w_dado);
   assign w_estado_code = r_state;

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_INICIAL:    if (iniciar) w_next = ST_PREPARACAO;
         ST_PREPARACAO: w_next = ST_ESPERA;
         ST_ESPERA: begin
            // a play arriving on the last timer cycle still counts
            if (w_jogada)               w_next = ST_REGISTRA;
            else if (r_timer == TC_LAST) w_next = ST_FIM_TIMEOUT;
         end
         ST_REGISTRA:   w_next = ST_COMPARACAO;
         ST_COMPARACAO: begin
            if (!w_igual)                w_next = ST_FIM_ERROU;
            else if (r_contagem == 4'hF) w_next = ST_FIM_ACERTOU;
            else                         w_next = ST_PROXIMO;
         end
         ST_PROXIMO:    w_next = ST_ESPERA;
         ST_FIM_ACERTOU,
         ST_FIM_ERROU,
         ST_FIM_TIMEOUT: if (iniciar) w_next = ST_PREPARACAO;
         default:       w_next = ST_INICIAL;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state    <= ST_INICIAL;
         r_status   <= '0;
         r_contagem <= 4'd0;
         r_jogada   <= 4'd0;
         r_timer    <= '0;
         r_prev     <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_status <= status_of(w_next);
         r_prev   <= w_tem_jogada;
         case (r_state)
            ST_PREPARACAO: begin
               r_contagem <= 4'd0;
               r_jogada   <= 4'd0;
               r_timer    <= '0;
            end
            ST_ESPERA:   r_timer  <= r_timer + TW'(1);
            ST_REGISTRA: r_jogada <= chaves;
            ST_PROXIMO: begin
               r_contagem <= r_contagem + 4'd1;
               r_timer    <= '0;
            end
            default: ;
         endcase
      end
   end

   assign acertou       = r_status.acertou;
   assign errou         = r_status.errou;
   assign pronto        = r_status.pronto;
   assign db_timeout    = r_status.timeout;
   assign leds          = chaves;
   assign db_igual      = w_igual;
   assign db_clock      = clock;
   assign db_iniciar    = iniciar;
   assign db_tem_jogada = w_tem_jogada;

   hexa7seg u_hex_contagem (.i_hexa(r_contagem),    .o_seg(db_contagem));
   hexa7seg u_hex_memoria  (.i_hexa(w_dado),        .o_seg(db_memoria));
   hexa7seg u_hex_estado   (.i_hexa(w_estado_code), .o_seg(db_estado));
   hexa7seg u_hex_jogada   (.i_hexa(r_jogada),      .o_seg(db_jogadafeita));

endmodule

// File: tb/tb_circuito_exp4_desafio.sv
// Self-checking bench for the memory game top: table-driven plays with a
// scoreboard queue of expected display/status snapshots.
module tb_circuito_exp4_desafio;

   localparam int T = 5000;

   logic       clock;
   logic       reset;
   logic       iniciar;
   logic [3:0] chaves;
   logic       acertou, errou, pronto, db_igual, db_timeout;
   logic       db_clock, db_iniciar, db_tem_jogada;
   logic [3:0] leds;
   logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita;

   circuito_exp4_desafio #(.TIMEOUT_CYCLES(T)) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
      .acertou(acertou), .errou(errou), .pronto(pronto), .leds(leds),
      .db_igual(db_igual), .db_timeout(db_timeout),
      .db_contagem(db_contagem), .db_memoria(db_memoria),
      .db_estado(db_estado), .db_jogadafeita(db_jogadafeita),
      .db_clock(db_clock), .db_iniciar(db_iniciar),
      .db_tem_jogada(db_tem_jogada)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      string      nm;
      logic [3:0] st;
      logic [3:0] cnt;
      logic [3:0] jog;
   } exp_t;

   typedef struct {
      logic [3:0] key;
      logic [3:0] fin;
   } vec_t;

   exp_t       sb[$];
   vec_t       tbl[16];
   int         n_asrt = 0;
   int         n_fail = 0;
   logic [3:0] cnt_m  = 4'd0;
   logic [3:0] reg_m  = 4'd0;

   function automatic logic [6:0] seg(input logic [3:0] h);
      case (h)
         4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;  default: return 7'b0001110;
      endcase
   endfunction

   function automatic logic [3:0] rom_tb(input logic [3:0] a);
      case (a)
         4'd0: return 4'd1;  4'd1: return 4'd2;  4'd2: return 4'd4;  4'd3: return 4'd8;
         4'd4: return 4'd4;  4'd5: return 4'd2;  4'd6: return 4'd1;  4'd7: return 4'd1;
         4'd8: return 4'd2;  4'd9: return 4'd2;  4'd10: return 4'd4; 4'd11: return 4'd4;
         4'd12: return 4'd8; 4'd13: return 4'd8; 4'd14: return 4'd1; default: return 4'd4;
      endcase
   endfunction

   // {acertou, errou, pronto, db_timeout}
   function automatic logic [3:0] flags_of(input logic [3:0] st);
      case (st)
         4'hA: return 4'b1010;
         4'hE: return 4'b0110;
         4'hD: return 4'b0111;
         default: return 4'b0000;
      endcase
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_asrt++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic push(input string nm, input logic [3:0] st, input logic [3:0] cnt,
                       input logic [3:0] jog);
      exp_t e;
      e.nm = nm; e.st = st; e.cnt = cnt; e.jog = jog;
      sb.push_back(e);
   endtask

   task automatic check_pop();
      exp_t e;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk({e.nm, "_estado"},  db_estado, seg(e.st));
         chk({e.nm, "_status"},  {acertou, errou, pronto, db_timeout}, flags_of(e.st));
         chk({e.nm, "_contagem"}, db_contagem, seg(e.cnt));
         chk({e.nm, "_memoria"}, db_memoria, seg(rom_tb(e.cnt)));
         chk({e.nm, "_jogada"},  db_jogadafeita, seg(e.jog));
      end
   endtask

   task automatic play(input logic [3:0] key, input logic [3:0] fin, input int hold,
                       input int idle);
      chaves = key;
      push("registra", 4'h4, cnt_m, reg_m);
      push("comparacao", 4'h5, cnt_m, key);
      push("decisao", fin, cnt_m, key);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_pop();
      end
      reg_m = key;
      chk("leds", leds, key);
      chk("tem_jogada", db_tem_jogada, 1'b1);
      repeat (hold - 3) tick();
      if (fin == 4'h6) cnt_m = cnt_m + 4'd1;
      push("hold", (fin == 4'h6) ? 4'h2 : fin, cnt_m, reg_m);
      check_pop();
      chaves = 4'd0;
      if (idle > 0) begin
         repeat (idle) tick();
         push("idle", (fin == 4'h6) ? 4'h2 : fin, cnt_m, reg_m);
         check_pop();
      end
   endtask

   task automatic start();
      iniciar = 1'b1;
      push("prep", 4'h1, cnt_m, reg_m);
      tick();
      check_pop();
      iniciar = 1'b0;
      cnt_m = 4'd0;
      reg_m = 4'd0;
      push("espera", 4'h2, cnt_m, reg_m);
      tick();
      check_pop();
   endtask

   task automatic full_win();
      for (int i = 0; i < 16; i++) play(tbl[i].key, tbl[i].fin, 10, 10);
      chk("win_acertou", acertou, 1'b1);
      chk("win_pronto", pronto, 1'b1);
      chk("win_errou", errou, 1'b0);
      chk("win_contagem", db_contagem, seg(4'hF));
   endtask

   initial begin
      int n;
      for (int i = 0; i < 16; i++) begin
         tbl[i].key = rom_tb(4'(i));
         tbl[i].fin = (i == 15) ? 4'hA : 4'h6;
      end

      reset = 1'b0; iniciar = 1'b0; chaves = 4'd0;
      push("reset", 4'h0, 4'd0, 4'd0);
      tick(); tick();
      check_pop();
      reset = 1'b1;

      // iniciar held five cycles: one PREPARACAO pass, then parked in ESPERA
      iniciar = 1'b1;
      push("prep_held", 4'h1, 4'd0, 4'd0);
      tick();
      check_pop();
      chk("db_iniciar", db_iniciar, 1'b1);
      for (int i = 0; i < 4; i++) begin
         push("espera_held", 4'h2, 4'd0, 4'd0);
         tick();
         check_pop();
      end
      iniciar = 1'b0;

      full_win();

      // miss at play 3
      start();
      play(tbl[0].key, 4'h6, 10, 10);
      play(tbl[1].key, 4'h6, 10, 10);
      play(4'b1000, 4'hE, 10, 10);
      chk("miss_acertou", acertou, 1'b0);

      // restart from FIM_ERROU and win
      start();
      full_win();

      // play on the last timer cycle beats timeout, then a real timeout
      start();
      repeat (T - 1) tick();
      push("espera_last", 4'h2, 4'd0, 4'd0);
      check_pop();
      play(4'b0001, 4'h6, 20, 0);
      n = 0;
      while (db_estado !== seg(4'hD) && n < T + 100) begin
         tick();
         n++;
      end
      chk("timeout_cycles", n, T - 16);
      push("timeout", 4'hD, cnt_m, reg_m);
      check_pop();

      // reset mid-game with counter at 5, iniciar asserted alongside
      start();
      for (int i = 0; i < 5; i++) play(tbl[i].key, tbl[i].fin, 10, 10);
      chk("mid_contagem", db_contagem, seg(4'd5));
      reset = 1'b0;
      iniciar = 1'b1;
      cnt_m = 4'd0;
      reg_m = 4'd0;
      push("mid_reset", 4'h0, 4'd0, 4'd0);
      tick();
      check_pop();
      reset = 1'b1;
      iniciar = 1'b0;
      push("after_reset", 4'h0, 4'd0, 4'd0);
      tick();
      check_pop();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule

// File: doc/circuito_exp4_desafio.md
Name: circuito_exp4_desafio

Overview:
- Top level of a single-player memory game ("desafio" variant of experiment 4). A fixed 16-entry sequence of one-hot 4-bit values sits in an internal ROM.
- The player reproduces the sequence on `chaves`, one play at a time.
- A Moore FSM plus datapath (address counter, play register, comparator, edge detector, inactivity timer) decides hit, miss or timeout.
- Debug outputs drive 7-segment displays and LEDs on the lab board.

Parameters:
- TIMEOUT_CYCLES, 5000, clock cycles allowed in the wait-for-play state before timeout (5 s at 1 kHz).

Ports:
- clock  in  1  system clock (1 kHz nominal). Single clock for the whole block.
- reset  in  1  synchronous, active-low reset.
- iniciar  in  1  start/restart game (level-sampled).
- chaves  in  4  player keys.
- acertou  out  1  game won.
- errou  out  1  game lost, by wrong play or by timeout.
- pronto  out  1  game finished.
- leds  out  4  mirror of chaves.
- db_igual  out  1  comparator output (play register == ROM data).
- db_timeout  out  1  game ended by timeout.
- db_contagem  out  7  7-seg of address counter.
- db_memoria  out  7  7-seg of ROM data.
- db_estado  out  7  7-seg of FSM state code.
- db_jogadafeita  out  7  7-seg of play register.
- db_clock  out  1  equals clock.
- db_iniciar  out  1  equals iniciar.
- db_tem_jogada  out  1  equals |chaves.

Behaviour:
- Reset is synchronous, active-low: sampled on the rising clock edge. While reset=0:
  - FSM goes to INICIAL.
  - Counter = 0, play register = 0, timer = 0, edge-detector history = 0.
  - acertou, errou, pronto and db_timeout = 0.
  - Reset wins over every other input.
- ROM contents, addresses 0..15 (combinational read at the counter address): 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4, i.e. one-hot values 0001, 0010, 0100, 1000, …
- Edge detector:
  - tem_jogada = |chaves; prev is a register of tem_jogada.
  - jogada = tem_jogada & ~prev (combinational).
  - A key held for N cycles produces exactly one pulse. Keys must return to 0000 before the next play is recognised.
- State codes (shown on db_estado as a hex digit) and transitions:
  - INICIAL 0: iniciar=1 -> PREPARACAO.
  - PREPARACAO 1: clear counter, play register and timer -> ESPERA.
  - ESPERA 2 (timer increments each cycle):
    - jogada=1 -> REGISTRA.
    - Otherwise, timer == TIMEOUT_CYCLES-1 -> FIM_TIMEOUT.
    - jogada takes priority over timeout in the same cycle.
  - REGISTRA 4: load play register with chaves -> COMPARACAO.
  - COMPARACAO 5:
    - igual & counter==15 -> FIM_ACERTOU.
    - igual & counter<15 -> PROXIMO.
    - ~igual -> FIM_ERROU.
  - PROXIMO 6: counter+1, timer cleared -> ESPERA.
  - FIM_ACERTOU A: pronto=1, acertou=1.
  - FIM_ERROU E: pronto=1, errou=1.
  - FIM_TIMEOUT D: pronto=1, errou=1, db_timeout=1.
  - In all three final states: iniciar=1 -> PREPARACAO (new game); otherwise stay.
- Outputs are Moore-decoded from state.
  - acertou/errou/pronto/db_timeout are 0 in every non-final state.
  - Multi-bit chaves values are compared as raw 4-bit words (so 0011 vs 0001 is a miss).
- Timer runs only in ESPERA. It saturates or is irrelevant elsewhere. Width = ceil(log2(TIMEOUT_CYCLES)).
- Latency: a key applied before rising edge k is recognised at edge k (-> REGISTRA), reaches COMPARACAO at k+1 and the final state or PROXIMO at k+2. acertou/errou are visible after edge k+2.
- 7-seg encoding: active-low segments, bit order {g,f,e,d,c,b,a}, hex 0-F (0 -> 1000000, F -> 0001110).
  - db_contagem shows the 4-bit counter.
  - db_memoria shows ROM data.
  - db_jogadafeita shows the play register.
  - db_estado shows the state code.
- iniciar held many cycles in INICIAL or a final state only causes the single transition to PREPARACAO. Holding it later has no effect in ESPERA.

Decomposition:
- Shared package holds: FSM state enum/codes (0,1,2,4,5,6,A,E,D), the 16-entry ROM contents, the default TIMEOUT_CYCLES.
- One natural sub-module, hexa7seg (4-bit in, 7-bit active-low out), instantiated four times.
- FSM, counter, register, timer and edge detector are written inline.

Test Plan:
- Reset pulse, then iniciar for 5 cycles, then the 16 correct plays (each held 10 cycles, 10 idle cycles between) -> db_estado passes 1,2,4,5,6…; after the 16th play acertou=1, pronto=1, errou=0, db_contagem=F.
- Correct plays 1-2, then 1000 at play 3 (expected 0100) -> errou=1, pronto=1, acertou=0, db_estado=E, db_jogadafeita=8.
- Start, then no key for TIMEOUT_CYCLES cycles -> FIM_TIMEOUT: errou=1, db_timeout=1, pronto=1. A key held 20 cycles before that does not time out.
- Key 0001 held 10 cycles -> exactly one REGISTRA/COMPARACAO pass; counter advances by 1 only.
- From FIM_ERROU, pulse iniciar -> PREPARACAO, counter 0, outputs cleared; a full correct run then wins.
- reset=0 asserted mid-game (counter=5) -> next edge: INICIAL, counter 0, all status outputs 0.
